// File: rtl/lcd_line_scheduler.sv
// rtl/lcd_line_scheduler.sv - HD44780 bus owner: power-up init, round-robin line writes, cursor restore
module lcd_line_scheduler #(
    parameter int POWERUP_CYC = 70
) (
    input  logic         clk_100hz,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic         line_sel0,
    input  logic         line_sel1,
    input  logic [127:0] text0,
    input  logic [127:0] text1,
    input  logic [6:0]   cursor_addr,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         busy,
    output logic         init_done,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data
);

    localparam int CNT_W = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        IDLE,
        ADDR,
        CHARS,
        CURSOR
    } state_t;

    state_t             state, state_n;
    logic               phase, phase_n;        // 0: e high, 1: e low (falling edge latches)
    logic [3:0]         idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               ptr, ptr_n;
    logic               winner, winner_n;
    logic               load;
    logic [127:0]       buf_text;

    logic               lcd_e_n, lcd_rs_n;
    logic [7:0]         lcd_data_n;
    logic [1:0]         gnt_n, done_n;
    logic               busy_n, init_done_n;

    logic               arb_win;
    logic               win_line;
    logic [3:0]         char_k;
    logic [7:0]         char_byte;

    function automatic logic [7:0] init_cmd(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h38;
            4'd1:    return 8'h0F;
            4'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // On a tie the requester that was not served last wins.
    assign arb_win   = (req == 2'b11) ? ~ptr : req[1];
    assign win_line  = arb_win ? line_sel1 : line_sel0;
    assign char_k    = (state == CHARS) ? (idx + 4'd1) : 4'd0;
    assign char_byte = buf_text[{~char_k, 3'b000} +: 8];
    assign lcd_rw    = 1'b0;

    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            state     <= PWRUP;
            phase     <= 1'b0;
            idx       <= 4'd0;
            cnt       <= '0;
            ptr       <= 1'b1;
            winner    <= 1'b0;
            buf_text  <= '0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            gnt       <= 2'b00;
            done      <= 2'b00;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            winner    <= winner_n;
            if (load) begin
                buf_text <= arb_win ? text1 : text0;
            end
            lcd_e     <= lcd_e_n;
            lcd_rs    <= lcd_rs_n;
            lcd_data  <= lcd_data_n;
            gnt       <= gnt_n;
            done      <= done_n;
            busy      <= busy_n;
            init_done <= init_done_n;
        end
    end

    // Bus outputs are registered; each branch that starts a byte sets up its phase A values.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        idx_n       = idx;
        cnt_n       = cnt;
        ptr_n       = ptr;
        winner_n    = winner;
        load        = 1'b0;
        lcd_e_n     = 1'b0;
        lcd_rs_n    = lcd_rs;
        lcd_data_n  = lcd_data;
        gnt_n       = gnt;
        done_n      = 2'b00;
        busy_n      = busy;
        init_done_n = init_done;

        case (state)
            PWRUP: begin
                if (cnt == CNT_W'(POWERUP_CYC - 1)) begin
                    state_n    = INIT;
                    phase_n    = 1'b0;
                    idx_n      = 4'd0;
                    lcd_e_n    = 1'b1;
                    lcd_rs_n   = 1'b0;
                    lcd_data_n = init_cmd(4'd0);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            INIT: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else if (idx == 4'd3) begin
                    state_n     = IDLE;
                    init_done_n = 1'b1;
                    busy_n      = 1'b0;
                end else begin
                    idx_n      = idx + 4'd1;
                    phase_n    = 1'b0;
                    lcd_e_n    = 1'b1;
                    lcd_data_n = init_cmd(idx + 4'd1);
                end
            end
            IDLE: begin
                if (|req) begin
                    load       = 1'b1;
                    winner_n   = arb_win;
                    gnt_n      = arb_win ? 2'b10 : 2'b01;
                    busy_n     = 1'b1;
                    state_n    = ADDR;
                    phase_n    = 1'b0;
                    lcd_e_n    = 1'b1;
                    lcd_rs_n   = 1'b0;
                    lcd_data_n = win_line ? 8'hC0 : 8'h80;
                end
            end
            ADDR: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    state_n    = CHARS;
                    phase_n    = 1'b0;
                    idx_n      = 4'd0;
                    lcd_e_n    = 1'b1;
                    lcd_rs_n   = 1'b1;
                    lcd_data_n = char_byte;
                end
            end
            CHARS: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else if (idx == 4'd15) begin
                    state_n    = CURSOR;
                    phase_n    = 1'b0;
                    lcd_e_n    = 1'b1;
                    lcd_rs_n   = 1'b0;
                    lcd_data_n = {1'b1, cursor_addr};
                end else begin
                    idx_n      = idx + 4'd1;
                    phase_n    = 1'b0;
                    lcd_e_n    = 1'b1;
                    lcd_data_n = char_byte;
                end
            end
            CURSOR: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    state_n = IDLE;
                    done_n  = winner ? 2'b10 : 2'b01;
                    gnt_n   = 2'b00;
                    busy_n  = 1'b0;
                    ptr_n   = winner;
                end
            end
            default: begin
                state_n = PWRUP;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// tb/tb_lcd_line_scheduler.sv - randomized self-checking bench for lcd_line_scheduler
module tb_lcd_line_scheduler;

    logic         clk_100hz = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   req = 2'b00;
    logic         line_sel0 = 1'b0;
    logic         line_sel1 = 1'b0;
    logic [127:0] text0 = '0;
    logic [127:0] text1 = '0;
    logic [6:0]   cursor_addr = 7'h00;
    logic [1:0]   gnt, done;
    logic         busy, init_done, lcd_e, lcd_rs, lcd_rw;
    logic [7:0]   lcd_data;

    int tests_run = 0;
    int failed = 0;
    int last = 1;

    lcd_line_scheduler #(.POWERUP_CYC(70)) dut (
        .clk_100hz   (clk_100hz),
        .rst         (rst),
        .req         (req),
        .line_sel0   (line_sel0),
        .line_sel1   (line_sel1),
        .text0       (text0),
        .text1       (text1),
        .cursor_addr (cursor_addr),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .init_done   (init_done),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_data    (lcd_data)
    );

    always #5 clk_100hz = ~clk_100hz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests_run, failed);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk_100hz);
        @(negedge clk_100hz);
    endtask

    function automatic int model_arb(input logic [1:0] r, input int prev);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (prev == 0) ? 1 : 0;
    endfunction

    function automatic logic [7:0] col_byte(input logic [127:0] t, input int k);
        logic [127:0] sh;
        sh = t >> (8 * (15 - k));
        return sh[7:0];
    endfunction

    task automatic do_reset;
        @(negedge clk_100hz);
        rst = 1'b0;
        req = 2'b00;
        repeat (3) @(negedge clk_100hz);
        last = 1;
    endtask

    // Called at the sample point right after reset release (edge 0).
    task automatic test_init(input bit req_at10);
        logic [7:0] cmds [4];
        int e_err, g_err, p_err;
        cmds[0] = 8'h38; cmds[1] = 8'h0F; cmds[2] = 8'h06; cmds[3] = 8'h01;
        e_err = 0; g_err = 0; p_err = 0;
        for (int k = 1; k <= 69; k++) begin
            step;
            if (lcd_e !== 1'b0) e_err++;
            if (gnt !== 2'b00 || done !== 2'b00 || init_done !== 1'b0 || busy !== 1'b1) g_err++;
            if (req_at10 && k == 10) req = 2'b10;
        end
        tests_run++;
        if (e_err !== 0) begin failed++; $display("FAIL pwrup_e_low: %0d cycles with lcd_e high, need 0", e_err); end
        for (int b = 0; b < 4; b++) begin
            step;
            tests_run++;
            if ({lcd_e, lcd_rs, lcd_data} !== {2'b10, cmds[b]}) begin
                failed++;
                $display("FAIL init_cmd%0d: e/rs/data=%b/%b/%h, need 1/0/%h", b, lcd_e, lcd_rs, lcd_data, cmds[b]);
            end
            if (gnt !== 2'b00 || done !== 2'b00 || init_done !== 1'b0) g_err++;
            step;
            if ({lcd_e, lcd_rs, lcd_data} !== {2'b00, cmds[b]}) p_err++;
            if (gnt !== 2'b00 || done !== 2'b00 || init_done !== 1'b0) g_err++;
        end
        tests_run++;
        if (p_err !== 0) begin failed++; $display("FAIL init_phase_b: %0d bad phase B cycles, need 0", p_err); end
        step;
        tests_run++;
        if ({init_done, busy, lcd_e} !== 3'b100) begin
            failed++;
            $display("FAIL init_done_78: init_done/busy/e=%b/%b/%b, need 1/0/0", init_done, busy, lcd_e);
        end
        tests_run++;
        if (g_err !== 0) begin failed++; $display("FAIL init_no_grant: %0d cycles with gnt/done/status wrong, need 0", g_err); end
    endtask

    task automatic run_txn(input int max_wait, input bit mutate, output int waited);
        int win, perr;
        logic [1:0] exp_g;
        logic [8:0] exp_b [18];
        logic [8:0] a;
        logic [127:0] t;
        logic sel;
        waited = 0;
        while (gnt === 2'b00 && waited < max_wait) begin
            step;
            waited++;
        end
        tests_run++;
        if (gnt === 2'b00) begin
            failed++;
            $display("FAIL gnt_timeout: no gnt within %0d cycles, req=%b", max_wait, req);
            return;
        end
        win = model_arb(req, last);
        exp_g = (win == 1) ? 2'b10 : 2'b01;
        t   = (win == 1) ? text1 : text0;
        sel = (win == 1) ? line_sel1 : line_sel0;
        exp_b[0] = {1'b0, sel ? 8'hC0 : 8'h80};
        for (int k = 0; k < 16; k++) exp_b[k + 1] = {1'b1, col_byte(t, k)};
        exp_b[17] = {1'b0, 8'h80 + {1'b0, cursor_addr}};
        tests_run++;
        if (gnt !== exp_g) begin failed++; $display("FAIL gnt_winner: gnt=%b, need %b (req=%b)", gnt, exp_g, req); end
        perr = 0;
        for (int j = 0; j < 18; j++) begin
            tests_run++;
            if ({lcd_rs, lcd_data} !== exp_b[j]) begin
                failed++;
                $display("FAIL txn_byte%0d: rs/data=%b/%h, need %b/%h", j, lcd_rs, lcd_data, exp_b[j][8], exp_b[j][7:0]);
            end
            if (lcd_e !== 1'b1 || gnt !== exp_g || busy !== 1'b1 || done !== 2'b00) perr++;
            a = {lcd_rs, lcd_data};
            if (mutate && j == 2) begin
                text0 = {$urandom, $urandom, $urandom, $urandom};
                req[0] = 1'b0;
            end
            step;
            if (lcd_e !== 1'b0 || {lcd_rs, lcd_data} !== a || gnt !== exp_g || busy !== 1'b1 || done !== 2'b00) perr++;
            step;
        end
        tests_run++;
        if (perr !== 0) begin failed++; $display("FAIL txn_protocol: %0d bad cycles, need 0", perr); end
        tests_run++;
        if ({done, gnt, busy, lcd_e} !== {exp_g, 2'b00, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL txn_done: done/gnt/busy/e=%b/%b/%b/%b, need %b/00/0/0", done, gnt, busy, lcd_e, exp_g);
        end
        last = win;
    endtask

    task automatic test_reset;
        do_reset;
        tests_run++;
        if ({lcd_e, lcd_rs, lcd_rw, lcd_data, gnt, done, busy, init_done} !== {3'b000, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL reset_values: e/rs/rw/data/gnt/done/busy/init=%b/%b/%b/%h/%b/%b/%b/%b, need 0/0/0/00/00/00/1/0",
                     lcd_e, lcd_rs, lcd_rw, lcd_data, gnt, done, busy, init_done);
        end
        rst = 1'b1;
        test_init(1'b0);
    endtask

    task automatic test_single;
        int w, bad;
        text0 = "1.Coke 1000W  ^ ";
        line_sel0 = 1'b0;
        cursor_addr = 7'h0D;
        req = 2'b01;
        run_txn(5, 1'b0, w);
        tests_run++;
        if (w !== 1) begin failed++; $display("FAIL single_latency: waited %0d, need 1", w); end
        req = 2'b00;
        bad = 0;
        repeat (5) begin step; if (gnt !== 2'b00 || lcd_e !== 1'b0) bad++; end
        tests_run++;
        if (bad !== 0) begin failed++; $display("FAIL single_no_regrant: %0d bad idle cycles, need 0", bad); end
    endtask

    task automatic test_back_to_back;
        int w;
        line_sel0 = 1'($urandom);
        line_sel1 = 1'b1;
        cursor_addr = 7'($urandom);
        text0 = {$urandom, $urandom, $urandom, $urandom};
        text1 = {$urandom, $urandom, $urandom, $urandom};
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_txn(40, 1'b0, w);
            tests_run++;
            if (w !== 1) begin failed++; $display("FAIL b2b_spacing%0d: waited %0d, need 1", i, w); end
            text0 = {$urandom, $urandom, $urandom, $urandom};
            text1 = {$urandom, $urandom, $urandom, $urandom};
        end
        req = 2'b00;
        step;
    endtask

    task automatic test_random;
        int w, bad;
        logic [1:0] r;
        for (int i = 0; i < 8; i++) begin
            r = 2'($urandom_range(0, 3));
            req = r;
            line_sel0 = 1'($urandom);
            line_sel1 = 1'($urandom);
            cursor_addr = 7'($urandom);
            text0 = {$urandom, $urandom, $urandom, $urandom};
            text1 = {$urandom, $urandom, $urandom, $urandom};
            if (r == 2'b00) begin
                bad = 0;
                repeat (4) begin step; if (gnt !== 2'b00 || busy !== 1'b0) bad++; end
                tests_run++;
                if (bad !== 0) begin failed++; $display("FAIL rand_idle%0d: %0d bad cycles, need 0", i, bad); end
            end else begin
                run_txn(5, 1'b0, w);
                tests_run++;
                if (w !== 1) begin failed++; $display("FAIL rand_latency%0d: waited %0d, need 1", i, w); end
            end
        end
        req = 2'b00;
        step;
    endtask

    task automatic test_mid_change;
        int w, bad;
        line_sel0 = 1'($urandom);
        text0 = {$urandom, $urandom, $urandom, $urandom};
        req = 2'b01;
        run_txn(5, 1'b1, w);
        bad = 0;
        repeat (3) begin step; if (gnt !== 2'b00) bad++; end
        tests_run++;
        if (bad !== 0) begin failed++; $display("FAIL mid_change_no_regrant: %0d cycles with gnt, need 0", bad); end
    endtask

    task automatic test_reset_mid;
        int w, n;
        logic [8:0] exp7;
        line_sel0 = 1'($urandom);
        text0 = {$urandom, $urandom, $urandom, $urandom};
        exp7 = {1'b1, col_byte(text0, 7)};
        req = 2'b01;
        n = 0;
        while (gnt === 2'b00 && n < 5) begin step; n++; end
        repeat (16) step;
        tests_run++;
        if ({lcd_e, lcd_rs, lcd_data} !== {1'b1, exp7}) begin
            failed++;
            $display("FAIL mid_byte7: e/rs/data=%b/%b/%h, need 1/1/%h", lcd_e, lcd_rs, lcd_data, exp7[7:0]);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({lcd_e, lcd_rs, lcd_rw, lcd_data, gnt, done, busy, init_done} !== {3'b000, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL mid_reset_values: e/rs/rw/data/gnt/done/busy/init=%b/%b/%b/%h/%b/%b/%b/%b, need 0/0/0/00/00/00/1/0",
                     lcd_e, lcd_rs, lcd_rw, lcd_data, gnt, done, busy, init_done);
        end
        last = 1;
        repeat (2) @(negedge clk_100hz);
        rst = 1'b1;
        test_init(1'b0);
        run_txn(5, 1'b0, w);
        tests_run++;
        if (w !== 1) begin failed++; $display("FAIL mid_reset_served: waited %0d, need 1", w); end
        req = 2'b00;
        step;
    endtask

    task automatic test_pending_during_init;
        int w;
        do_reset;
        rst = 1'b1;
        line_sel1 = 1'($urandom);
        text1 = {$urandom, $urandom, $urandom, $urandom};
        test_init(1'b1);
        run_txn(5, 1'b0, w);
        tests_run++;
        if (w !== 1) begin failed++; $display("FAIL pending_first_idle: waited %0d, need 1", w); end
        req = 2'b00;
        step;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_random;
        test_mid_change;
        test_reset_mid;
        test_pending_during_init;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
